shiftreg_vld: RTL and testbench

- Valid-qualified, clock-enabled, multi-channel delay line; successor to the fixed-latency data-only delay register.
- Adds runtime-selectable latency (0..MAX_SHIFT) with safe switchover, a valid pipeline with reset and flush, stall via clock enable, and an occupancy count.
- Used to align datapaths whose depth changes with mode, e.g. bypassed versus full multiplier stages, between compute stages.

---
 rtl/shiftreg_vld.sv | 128 ++++++++++++
 tb/tb_shiftreg_vld.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/shiftreg_vld.sv
// Valid-qualified, clock-enabled, multi-channel delay line with runtime latency (0..MAX_SHIFT).
// Optional occupancy counter: define SHIFTREG_VLD_OCC_EN; otherwise occ_o is tied to 0.
module shiftreg_vld #(
   parameter int MAX_SHIFT = 8,
   parameter int DATA_W    = 64,
   parameter int N_CH      = 1,
   parameter     USE_SHR   = "true",
   localparam int SEL_W    = $clog2(MAX_SHIFT + 1),
   localparam int W        = N_CH * DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce_i,
   input  logic             flush_i,
   input  logic [SEL_W-1:0] shift_sel_i,
   input  logic             valid_i,
   input  logic [W-1:0]     data_i,
   output logic             valid_o,
   output logic [W-1:0]     data_o,
   output logic [SEL_W-1:0] occ_o,
   output logic             busy_o
);

   if (MAX_SHIFT < 1) begin : g_bad_param
      $error("shiftreg_vld: MAX_SHIFT must be >= 1");
   end

   function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
      return (s > SEL_W'(MAX_SHIFT)) ? SEL_W'(MAX_SHIFT) : s;
   endfunction

   logic [SEL_W-1:0]   sel_in, sel_act, sel_pend, tap_idx;
   logic [MAX_SHIFT:1] v, v_shift;
   logic [W-1:0]       tap_data;
   logic               bypass, v_tap, in_fire, live_zero, apply;

   assign sel_in  = clamp_sel(shift_sel_i);
   assign bypass  = (sel_act == '0);
   // Keep the tap index legal in bypass; the stage value is ignored then.
   assign tap_idx = bypass ? SEL_W'(1) : sel_act;
   assign v_tap   = v[tap_idx];
   assign v_shift = MAX_SHIFT'({v, valid_i});
   assign in_fire = ce_i & valid_i;

   assign busy_o  = (sel_pend != sel_act);
   assign apply   = busy_o & live_zero & ~in_fire;

   // Flush outranks a latency apply, which outranks a normal advance.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         v        <= '0;
         sel_act  <= sel_in;
         sel_pend <= sel_in;
      end else begin
         sel_pend <= sel_in;
         if (flush_i) begin
            v <= '0;
         end else if (apply) begin
            v       <= '0;
            sel_act <= sel_pend;
         end else if (ce_i) begin
            v <= v_shift;
         end
      end
   end

`ifdef SHIFTREG_VLD_OCC_EN
   logic [SEL_W-1:0] occ;

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         occ <= '0;
      end else if (ce_i && !apply && !bypass) begin
         occ <= occ + SEL_W'(valid_i) - SEL_W'(v_tap);
      end
   end

   assign live_zero = (occ == '0);
   assign occ_o     = occ;
`else
   logic [MAX_SHIFT:1] in_range;

   always_comb begin
      // NOTE: default first so no path through this block can infer a latch.
      in_range = '0;
      for (int k = 1; k <= MAX_SHIFT; k++) begin
         in_range[k] = (SEL_W'(k) <= sel_act);
      end
   end

   assign live_zero = ~|(v & in_range);
   assign occ_o     = '0;
`endif

   if (USE_SHR == "true") begin : g_shreg
      (* shreg_extract = "yes" *) logic [W-1:0] d [1:MAX_SHIFT];

      // NOTE: data stages carry no reset; the valid bits alone qualify them, which keeps them SRL-friendly.
      always_ff @(posedge clk) begin
         if (ce_i) begin
            d[1] <= data_i;
            for (int k = 2; k <= MAX_SHIFT; k++) begin
               d[k] <= d[k-1];
            end
         end
      end

      assign tap_data = d[tap_idx];
   end else begin : g_flops
      (* shreg_extract = "no" *) logic [W-1:0] d [1:MAX_SHIFT];

      always_ff @(posedge clk) begin
         if (ce_i) begin
            d[1] <= data_i;
            for (int k = 2; k <= MAX_SHIFT; k++) begin
               d[k] <= d[k-1];
            end
         end
      end

      assign tap_data = d[tap_idx];
   end

   assign valid_o = ce_i & (bypass ? valid_i : v_tap);
   assign data_o  = bypass ? data_i : tap_data;

endmodule

// File: tb/tb_shiftreg_vld.sv
// Directed bench for shiftreg_vld: fixed latency, stall, bypass, latency switch, flush, clamp, reset.
module tb_shiftreg_vld;

   localparam int MAX_SHIFT = 8;
   localparam int DATA_W    = 64;
   localparam int SEL_W     = $clog2(MAX_SHIFT + 1);
`ifdef SHIFTREG_VLD_OCC_EN
   localparam bit OCC_EN = 1'b1;
`else
   localparam bit OCC_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              ce_i;
   logic              flush_i;
   logic [SEL_W-1:0]  shift_sel_i;
   logic              valid_i;
   logic [DATA_W-1:0] data_i;
   logic              valid_o;
   logic [DATA_W-1:0] data_o;
   logic [SEL_W-1:0]  occ_o;
   logic              busy_o;

   int    n_tests = 0;
   int    n_fail  = 0;
   string tname   = "init";
   int    idx     = 0;

   always #5 clk = ~clk;

   shiftreg_vld #(
      .MAX_SHIFT (MAX_SHIFT),
      .DATA_W    (DATA_W),
      .N_CH      (1),
      .USE_SHR   ("true")
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ce_i        (ce_i),
      .flush_i     (flush_i),
      .shift_sel_i (shift_sel_i),
      .valid_i     (valid_i),
      .data_i      (data_i),
      .valid_o     (valid_o),
      .data_o      (data_o),
      .occ_o       (occ_o),
      .busy_o      (busy_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One clock: drive inputs, let the bypass path settle, check, then advance.
   task automatic cyc(input logic ce, input logic fl, input logic vld, input logic [63:0] din,
                      input logic evo, input logic [63:0] edo, input bit chkd,
                      input logic [SEL_W-1:0] eocc, input logic ebusy);
      ce_i    = ce;
      flush_i = fl;
      valid_i = vld;
      data_i  = din;
      #2;
      check($sformatf("%s[%0d].valid_o", tname, idx), 64'(valid_o), 64'(evo));
      if (chkd) check($sformatf("%s[%0d].data_o", tname, idx), data_o, edo);
      check($sformatf("%s[%0d].occ_o", tname, idx), 64'(occ_o), OCC_EN ? 64'(eocc) : 64'd0);
      check($sformatf("%s[%0d].busy_o", tname, idx), 64'(busy_o), 64'(ebusy));
      idx++;
      tick();
   endtask

   task automatic do_reset(input logic [SEL_W-1:0] sel, input logic ce, input logic vld);
      rst         = 1'b1;
      shift_sel_i = sel;
      ce_i        = ce;
      valid_i     = vld;
      flush_i     = 1'b0;
      data_i      = 64'hFF;
      tick();
      rst = 1'b0;
      idx = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; ce_i = 1'b0; flush_i = 1'b0; shift_sel_i = '0; valid_i = 1'b0; data_i = '0;

      // Fixed latency 3
      do_reset(3, 0, 0); tname = "fixed";
      cyc(1, 0, 1, 64'hA1, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 64'hA2, 0, 0, 0, 1, 0);
      cyc(1, 0, 1, 64'hA3, 0, 0, 0, 2, 0);
      cyc(1, 0, 0, 64'h0,  1, 64'hA1, 1, 3, 0);
      cyc(1, 0, 0, 64'h0,  1, 64'hA2, 1, 2, 0);
      cyc(1, 0, 0, 64'h0,  1, 64'hA3, 1, 1, 0);
      cyc(1, 0, 0, 64'h0,  0, 0, 0, 0, 0);

      // Stall: latency 4, ce low for 5 cycles after the 2nd advance; valid_i there must be ignored
      do_reset(4, 0, 0); tname = "stall";
      cyc(1, 0, 1, 64'h55, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 64'h0,  0, 0, 0, 1, 0);
      repeat (5) cyc(0, 0, 1, 64'hDEAD, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 64'h0, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 64'h0, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 64'h0, 1, 64'h55, 1, 1, 0);
      cyc(1, 0, 0, 64'h0, 0, 0, 0, 0, 0);

      // Bypass: combinational path, valid qualified by ce
      do_reset(0, 0, 0); tname = "bypass";
      cyc(1, 0, 1, 64'h1234, 1, 64'h1234, 1, 0, 0);
      cyc(0, 0, 1, 64'hBEEF, 0, 64'hBEEF, 1, 0, 0);
      cyc(1, 0, 0, 64'h77,   0, 64'h77,   1, 0, 0);

      // Latency switch 2 -> 5 with two items in flight
      do_reset(2, 0, 0); tname = "switch";
      cyc(1, 0, 1, 64'hB1, 0, 0, 0, 0, 0);
      shift_sel_i = 5;
      cyc(1, 0, 1, 64'hB2, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 64'h0,  1, 64'hB1, 1, 2, 1);
      cyc(1, 0, 0, 64'h0,  1, 64'hB2, 1, 1, 1);
      cyc(1, 0, 0, 64'h0,  0, 0, 0, 0, 1);
      cyc(1, 0, 1, 64'hC1, 0, 0, 0, 0, 0);
      repeat (4) cyc(1, 0, 0, 64'h0, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 64'h0, 1, 64'hC1, 1, 1, 0);
      cyc(1, 0, 0, 64'h0, 0, 0, 0, 0, 0);

      // Flush with four items in flight and a colliding valid_i
      do_reset(6, 0, 0); tname = "flush";
      cyc(1, 0, 1, 64'hD0, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 64'hD1, 0, 0, 0, 1, 0);
      cyc(1, 0, 1, 64'hD2, 0, 0, 0, 2, 0);
      cyc(1, 0, 1, 64'hD3, 0, 0, 0, 3, 0);
      cyc(1, 1, 1, 64'hDF, 0, 0, 0, 4, 0);
      repeat (7) cyc(1, 0, 0, 64'h0, 0, 0, 0, 0, 0);

      // Data leaving the tap in the flush cycle is still delivered
      do_reset(1, 0, 0); tname = "flush_tap";
      cyc(1, 0, 1, 64'hE1, 0, 0, 0, 0, 0);
      cyc(1, 1, 0, 64'h0,  1, 64'hE1, 1, 1, 0);
      cyc(1, 0, 0, 64'h0,  0, 0, 0, 0, 0);

      // Clamp: 11 behaves as 8 and never looks like a pending change
      do_reset(11, 0, 0); tname = "clamp";
      cyc(1, 0, 1, 64'hF1, 0, 0, 0, 0, 0);
      repeat (7) cyc(1, 0, 0, 64'h0, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 64'h0,  1, 64'hF1, 1, 1, 0);
      cyc(1, 0, 1, 64'hF2, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 64'hF3, 0, 0, 0, 1, 0);

      // Reset mid-stream with ce and valid high: nothing may emerge afterwards
      do_reset(11, 1, 1); tname = "reset_mid";
      repeat (9) cyc(1, 0, 0, 64'h0, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
